// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared constants for the pong game controller and graphics.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam logic [1:0] GS_NEWGAME = 2'd0;
    localparam logic [1:0] GS_PLAY    = 2'd1;
    localparam logic [1:0] GS_NEWBALL = 2'd2;
    localparam logic [1:0] GS_OVER    = 2'd3;

    localparam int DEF_LIVES       = 3;
    localparam int DEF_TIMER_TICKS = 120;
    localparam int DEF_SCORE_MAX   = 99;

    // Screen geometry shared with the graphics block
    localparam int MAX_X = 640;
    localparam int MAX_Y = 480;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/pong_bcd_score.sv
`default_nettype none
// ============================================================================
//  Module      : pong_bcd_score
//  Description : Two-digit BCD score counter with clear, increment and
//                saturation at SCORE_MAX; flags units-digit wrap 9 -> 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_bcd_score #(
    parameter int SCORE_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       wrap_o
);

    localparam logic [3:0] MAX_D1 = 4'(SCORE_MAX / 10);
    localparam logic [3:0] MAX_D0 = 4'(SCORE_MAX % 10);

    logic [3:0] d1_q, d1_d;
    logic [3:0] d0_q, d0_d;
    logic       sat;

    assign sat    = (d1_q == MAX_D1) && (d0_q == MAX_D0);
    assign wrap_o = inc && !clr && !sat && (d0_q == 4'd9);

    always_comb begin
        d1_d = d1_q;
        d0_d = d0_q;
        if (clr) begin
            d1_d = 4'd0;
            d0_d = 4'd0;
        end else if (inc && !sat) begin
            if (d0_q == 4'd9) begin
                d0_d = 4'd0;
                d1_d = d1_q + 4'd1;
            end else begin
                d0_d = d0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q <= 4'd0;
            d0_q <= 4'd0;
        end else begin
            d1_q <= d1_d;
            d0_q <= d0_d;
        end
    end

    assign d1 = d1_q;
    assign d0 = d0_q;

endmodule : pong_bcd_score
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pong_game_ctrl
//  Description : Pong game sequencer: serve/freeze control, lives, BCD score.
//                Optional ball speed-up selected by macro PONG_SPEEDUP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES       = DEF_LIVES,
    parameter int TIMER_TICKS = DEF_TIMER_TICKS,
    parameter int SCORE_MAX   = DEF_SCORE_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refr_tick,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic       ball_reload,
    output logic [1:0] state_o,
    output logic [1:0] balls_left,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [1:0] speed_lvl
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [6:0] TIMER_INIT = 7'(TIMER_TICKS);

    logic [1:0] state_q, state_d;
    logic [1:0] balls_q, balls_d;
    logic [6:0] timer_q, timer_d;
    logic       reload_q, reload_d;
    logic       score_clr;
    logic       score_inc;
    logic       score_wrap;
    logic       press;

    assign press = |btn;

    always_comb begin
        state_d   = state_q;
        balls_d   = balls_q;
        timer_d   = timer_q;
        reload_d  = 1'b0;
        score_clr = 1'b0;
        score_inc = 1'b0;
        case (state_q)
            GS_NEWGAME: begin
                if (press) begin
                    state_d   = GS_PLAY;
                    score_clr = 1'b1;
                    reload_d  = 1'b1;
                end
            end
            GS_PLAY: begin
                // A miss takes priority over a simultaneous hit
                if (miss) begin
                    timer_d = TIMER_INIT;
                    if (balls_q == 2'd1) begin
                        balls_d = 2'd0;
                        state_d = GS_OVER;
                    end else begin
                        balls_d = balls_q - 2'd1;
                        state_d = GS_NEWBALL;
                    end
                end else if (hit) begin
                    score_inc = 1'b1;
                end
            end
            GS_NEWBALL: begin
                if (timer_q != 7'd0) begin
                    if (refr_tick) timer_d = timer_q - 7'd1;
                end else if (press) begin
                    state_d  = GS_PLAY;
                    reload_d = 1'b1;
                end
            end
            GS_OVER: begin
                if (timer_q != 7'd0) begin
                    if (refr_tick) timer_d = timer_q - 7'd1;
                end else begin
                    state_d = GS_NEWGAME;
                    balls_d = LIVES_INIT;
                end
            end
            default: state_d = GS_NEWGAME;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= GS_NEWGAME;
            balls_q  <= LIVES_INIT;
            timer_q  <= 7'd0;
            reload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            balls_q  <= balls_d;
            timer_q  <= timer_d;
            reload_q <= reload_d;
        end
    end

    pong_bcd_score #(
        .SCORE_MAX (SCORE_MAX)
    ) u_score (
        .clk    (clk),
        .rst    (rst),
        .clr    (score_clr),
        .inc    (score_inc),
        .d1     (score_d1),
        .d0     (score_d0),
        .wrap_o (score_wrap)
    );

`ifdef PONG_SPEEDUP_EN
    logic [1:0] speed_q, speed_d;

    always_comb begin
        speed_d = speed_q;
        if (score_clr) begin
            speed_d = 2'd0;
        end else if (score_wrap && (speed_q != 2'd3)) begin
            speed_d = speed_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q <= 2'd0;
        end else begin
            speed_q <= speed_d;
        end
    end

    assign speed_lvl = speed_q;
`else
    logic unused_wrap;
    assign unused_wrap = score_wrap;
    assign speed_lvl   = 2'd0;
`endif

    assign gra_still   = (state_q != GS_PLAY);
    assign ball_reload = reload_q;
    assign state_o     = state_q;
    assign balls_left  = balls_q;

endmodule : pong_game_ctrl
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_game_ctrl
//  Description : Directed self-checking bench for pong_game_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

`ifdef PONG_SPEEDUP_EN
    localparam int SPD_EN = 1;
`else
    localparam int SPD_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       refr_tick;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic       gra_still;
    logic       ball_reload;
    logic [1:0] state_o;
    logic [1:0] balls_left;
    logic [3:0] score_d1;
    logic [3:0] score_d0;
    logic [1:0] speed_lvl;

    int n_tests = 0;
    int n_fail  = 0;

    pong_game_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .refr_tick   (refr_tick),
        .btn         (btn),
        .hit         (hit),
        .miss        (miss),
        .gra_still   (gra_still),
        .ball_reload (ball_reload),
        .state_o     (state_o),
        .balls_left  (balls_left),
        .score_d1    (score_d1),
        .score_d0    (score_d0),
        .speed_lvl   (speed_lvl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] btn;
        logic       hit;
        logic       miss;
        logic       refr;
        logic [1:0] st;
        logic       still;
        logic       rl;
        logic [1:0] balls;
        logic [3:0] d1;
        logic [3:0] d0;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic still,
                           input logic rl, input logic [1:0] balls,
                           input logic [3:0] d1, input logic [3:0] d0,
                           input logic [1:0] spd);
        chk({tag, ".state"},  {6'd0, state_o},    {6'd0, st});
        chk({tag, ".still"},  {7'd0, gra_still},  {7'd0, still});
        chk({tag, ".reload"}, {7'd0, ball_reload},{7'd0, rl});
        chk({tag, ".balls"},  {6'd0, balls_left}, {6'd0, balls});
        chk({tag, ".d1"},     {4'd0, score_d1},   {4'd0, d1});
        chk({tag, ".d0"},     {4'd0, score_d0},   {4'd0, d0});
        chk({tag, ".speed"},  {6'd0, speed_lvl},  {6'd0, spd});
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the active edge
    task automatic cyc(input logic [1:0] b, input logic h, input logic m, input logic r);
        btn = b; hit = h; miss = m; refr_tick = r;
        @(posedge clk);
        #1;
        btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
    endtask

    initial begin
        //           btn    hit   miss  refr  st  still rl  balls d1 d0
        vecs[0]  = '{2'b01, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'd3, 4'd0, 4'd0};
        vecs[1]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd0};
        vecs[2]  = '{2'b00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd1};
        vecs[3]  = '{2'b00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd2};
        vecs[4]  = '{2'b00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd3};
        vecs[5]  = '{2'b00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd4};
        vecs[6]  = '{2'b00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd5};
        vecs[7]  = '{2'b00, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 2'd2, 4'd0, 4'd5};
        vecs[8]  = '{2'b01, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd2, 4'd0, 4'd5};
        vecs[9]  = '{2'b00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 2'd2, 4'd0, 4'd5};
        vecs[10] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 2'd2, 4'd0, 4'd5};

        rst = 1'b1; btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 2'd0, 1'b1, 1'b0, 2'd3, 4'd0, 4'd0, 2'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc(2'b00, 1'b0, 1'b0, (i % 3) == 0);
            chk_all("idle", 2'd0, 1'b1, 1'b0, 2'd3, 4'd0, 4'd0, 2'd0);
        end

        // Start, five hits, hit+miss (load cycle with refr), first countdown tick,
        // then hit/miss ignored outside PLAY
        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].btn, vecs[i].hit, vecs[i].miss, vecs[i].refr);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].still, vecs[i].rl,
                    vecs[i].balls, vecs[i].d1, vecs[i].d0, 2'd0);
        end

        // Ticks 2..120 with a button held: must stay in NEWBALL throughout
        for (int t = 2; t <= 120; t++) begin
            cyc(2'b01, 1'b0, 1'b0, 1'b1);
            chk($sformatf("nb_hold_t%0d.state", t), {6'd0, state_o}, 8'd2);
        end
        cyc(2'b10, 1'b0, 1'b0, 1'b0);
        chk_all("serve1", 2'd1, 1'b0, 1'b1, 2'd2, 4'd0, 4'd5, 2'd0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        chk("serve1_pulse_end", {7'd0, ball_reload}, 8'd0);

        // Second miss, countdown without buttons, then serve
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        chk_all("miss2", 2'd2, 1'b1, 1'b0, 2'd1, 4'd0, 4'd5, 2'd0);
        for (int t = 1; t <= 120; t++) cyc(2'b00, 1'b0, 1'b0, 1'b1);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        chk("nb_wait_nobtn.state", {6'd0, state_o}, 8'd2);
        cyc(2'b01, 1'b0, 1'b0, 1'b0);
        chk_all("serve2", 2'd1, 1'b0, 1'b1, 2'd1, 4'd0, 4'd5, 2'd0);

        // Last ball lost -> OVER, then back to NEWGAME with score kept
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        chk_all("over", 2'd3, 1'b1, 1'b0, 2'd0, 4'd0, 4'd5, 2'd0);
        for (int t = 1; t <= 120; t++) begin
            cyc(2'b11, 1'b0, 1'b0, 1'b1);
            chk($sformatf("over_t%0d.state", t), {6'd0, state_o}, 8'd3);
        end
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        chk_all("newgame", 2'd0, 1'b1, 1'b0, 2'd3, 4'd0, 4'd5, 2'd0);
        cyc(2'b01, 1'b0, 1'b0, 1'b0);
        chk_all("restart", 2'd1, 1'b0, 1'b1, 2'd3, 4'd0, 4'd0, 2'd0);

        for (int k = 0; k < 11; k++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
        chk_all("hits11", 2'd1, 1'b0, 1'b0, 2'd3, 4'd1, 4'd1, 2'(SPD_EN));
        for (int k = 0; k < 88; k++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
        chk_all("hits99", 2'd1, 1'b0, 1'b0, 2'd3, 4'd9, 4'd9, 2'(3 * SPD_EN));
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        chk_all("sat99", 2'd1, 1'b0, 1'b0, 2'd3, 4'd9, 4'd9, 2'(3 * SPD_EN));

        // Asynchronous reset in the middle of a NEWBALL countdown
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        chk("miss_sat.state", {6'd0, state_o}, 8'd2);
        repeat (3) cyc(2'b00, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk_all("rst_async", 2'd0, 1'b1, 1'b0, 2'd3, 4'd0, 4'd0, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset right after a start press cancels the pending reload pulse
        cyc(2'b01, 1'b0, 1'b0, 1'b0);
        chk("pre_cancel.reload", {7'd0, ball_reload}, 8'd1);
        rst = 1'b1;
        #1;
        chk_all("rst_cancel", 2'd0, 1'b1, 1'b0, 2'd3, 4'd0, 4'd0, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pong_game_ctrl
`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-level sequencer for the pong graphics datapath.
- Decides when the playfield animates or freezes, and requests a ball reposition on each serve.
- Counts remaining balls and keeps a 2-digit BCD score from hit/miss pulses reported by the graphics block.
- Sits between the button inputs, the VGA refresh tick and the graph/text renderers.

Parameters:
- LIVES, 3: balls per game, range 1..3.
- TIMER_TICKS, 120: refresh ticks in the pause timer (2 s at 60 Hz), range 1..127.
- SCORE_MAX, 99: saturation value of the BCD score.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- refr_tick  in  1  one-cycle pulse, once per frame (start of vsync).
- btn  in  2  paddle buttons, level, active-high; any nonzero value counts as "press".
- hit  in  1  one-cycle pulse: ball bounced off the paddle.
- miss  in  1  one-cycle pulse: ball passed the paddle (right edge).
- gra_still  out  1  1 = freeze ball/paddle animation.
- ball_reload  out  1  one-cycle pulse: graph reloads ball to serve position.
- state_o  out  2  current game state, for the text overlay.
- balls_left  out  2  remaining balls.
- score_d1  out  4  score tens digit, BCD.
- score_d0  out  4  score units digit, BCD.
- speed_lvl  out  2  ball speed level (see Optional Feature).

Behaviour:
- Moore FSM, states NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3. All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Reset values: state NEWGAME; balls_left=LIVES; score 00; timer 0; ball_reload 0; speed_lvl 0.
- gra_still=1 in every state except PLAY.
- NEWGAME: on btn!=0:
  - next state PLAY;
  - score cleared to 00 in the same cycle;
  - ball_reload=1 for exactly the following cycle.
- PLAY:
  - hit and not miss: score+1 in BCD (09 -> 10). At SCORE_MAX it holds, no wrap.
  - miss (hit ignored if both are set in the same cycle):
    - balls_left==1: balls_left<=0, timer<=TIMER_TICKS, go to OVER;
    - otherwise: balls_left-1, timer<=TIMER_TICKS, go to NEWBALL.
- NEWBALL:
  - timer decrements on each refr_tick while nonzero;
  - when timer==0 and btn!=0: go to PLAY and pulse ball_reload next cycle;
  - buttons held during the countdown have no effect until timer reaches 0.
- OVER: timer counts down as above. At timer==0, go to NEWGAME and load balls_left<=LIVES. The score is kept for display.
- Timer: 7-bit down-counter. Loads only on PLAY exit. Decrements only on refr_tick.
- refr_tick coincident with the load cycle: the load wins and no decrement occurs.
- hit/miss outside PLAY: ignored.
- rst mid-game: immediate return to reset values; a pending ball_reload is cancelled.
- BCD digits always stay in 0..9.

Optional Feature:
- Macro PONG_SPEEDUP_EN.
- Defined: speed_lvl increments (saturates at 3) each time the score units digit wraps 9 -> 0, i.e. every 10 points. It clears on NEWGAME -> PLAY.
- Not defined: speed_lvl is constant 0 and no extra logic is synthesized.

Decomposition:
- Package pong_pkg holds:
  - state encoding constants GS_NEWGAME/GS_PLAY/GS_NEWBALL/GS_OVER;
  - LIVES and TIMER_TICKS defaults;
  - the MAX_X=640 and MAX_Y=480 screen constants shared with the graphics block.
- One sub-module, pong_bcd_score: 2-digit BCD counter with clr, inc and saturate at SCORE_MAX. It outputs the d1/d0 digits and a units-wrap pulse used by the speed-up logic.

Test Plan:
- Reset, then idle 10 cycles -> state_o=0, gra_still=1, balls_left=3, score 00, ball_reload never asserted.
- btn=01 in NEWGAME -> state_o=1 next cycle, one-cycle ball_reload, gra_still=0, score 00.
- 11 hit pulses in PLAY -> score_d1=1, score_d0=1. With PONG_SPEEDUP_EN, speed_lvl=1.
- miss in PLAY with balls_left=3 -> NEWBALL, balls_left=2. btn held during countdown:
  - no PLAY before the 120th refr_tick;
  - after timer 0 with btn=10 -> PLAY plus ball_reload.
- Three misses -> OVER, balls_left=0. After 120 refr_ticks -> NEWGAME, balls_left=3, score still displayed. The next start press clears the score.
- hit and miss in the same cycle with score 05 -> score stays 05 and balls decrement. Preload score 99 plus a hit -> stays 99. Assert rst mid-NEWBALL -> all reset values immediately.
